// File: rtl/mux_sel_scheduler_pkg.sv
// Shared types and select encoding for the round-robin mux select scheduler.
// Select bit 1 picks the member of a pair (A/B, C/D); bit 0 picks the pair.
package mux_sel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b10;
    localparam logic [1:0] SEL_C = 2'b01;
    localparam logic [1:0] SEL_D = 2'b11;

    function automatic logic [1:0] onehot_to_sel(input logic [3:0] oh);
        logic [1:0] s;
        unique case (oh)
            4'b0010: s = SEL_B;
            4'b0100: s = SEL_C;
            4'b1000: s = SEL_D;
            default: s = SEL_A;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        unique case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mux_sel_scheduler_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping D->A.
// The masked channel is skipped unless it is the only requester.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic [3:0] mask,
    output logic [3:0] win_oh,
    output logic       any
);

    always_comb begin
        logic [3:0] masked;
        logic [3:0] src;
        logic [1:0] idx;
        logic       found;
        masked = req & ~mask;
        src    = (masked != '0) ? masked : req;
        win_oh = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && src[idx]) begin
                win_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin scheduler driving the 4:1 mux select with bursts of up to BURST beats
// under a valid/ready handshake. All outputs are registered.
module mux_sel_scheduler
    import mux_sel_pkg::*;
#(
    parameter int unsigned BURST = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       beat_last
);

    if (BURST < 1 || BURST > (1 << CNT_W) - 1) begin : g_bad_burst
        $error("mux_sel_scheduler: BURST must be in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic [3:0]       gnt_q;
    logic [1:0]       sel_q;
    logic             out_valid_q;
    logic             beat_last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       ptr_q;

    logic [1:0] gidx;
    logic [1:0] ptr_d;
    logic [1:0] arb_ptr;
    logic [3:0] arb_mask;
    logic [3:0] win_oh;
    logic       win_any;
    logic       cont;

    // While busy, arbitration already looks past the current grant so a finishing
    // burst can hand over to the next winner without a bubble.
    always_comb begin
        gidx     = onehot_to_idx(gnt_q);
        ptr_d    = gidx + 2'd1;
        arb_ptr  = (state_q == BUSY) ? ptr_d : ptr_q;
        arb_mask = (state_q == BUSY) ? gnt_q : '0;
        cont     = (cnt_q < BURST_C) && req[gidx];
    end

    rr_pick u_rr_pick (
        .req    (req),
        .ptr    (arb_ptr),
        .mask   (arb_mask),
        .win_oh (win_oh),
        .any    (win_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= SEL_A;
            out_valid_q <= 1'b0;
            beat_last_q <= 1'b0;
            cnt_q       <= '0;
            ptr_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_any) begin
                        state_q     <= BUSY;
                        gnt_q       <= win_oh;
                        sel_q       <= onehot_to_sel(win_oh);
                        out_valid_q <= 1'b1;
                        cnt_q       <= CNT_ONE;
                        beat_last_q <= (BURST_C == CNT_ONE);
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        if (cont) begin
                            cnt_q       <= cnt_q + 1'b1;
                            beat_last_q <= ((cnt_q + 1'b1) == BURST_C);
                        end else begin
                            ptr_q <= ptr_d;
                            if (win_any) begin
                                gnt_q       <= win_oh;
                                sel_q       <= onehot_to_sel(win_oh);
                                cnt_q       <= CNT_ONE;
                                beat_last_q <= (BURST_C == CNT_ONE);
                            end else begin
                                state_q     <= IDLE;
                                gnt_q       <= '0;
                                sel_q       <= SEL_A;
                                out_valid_q <= 1'b0;
                                beat_last_q <= 1'b0;
                                cnt_q       <= '0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign beat_last = beat_last_q;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed and randomized checks of the round-robin mux select scheduler,
// using BURST=4 and BURST=2 instances.
module tb_mux_sel_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic       beat_last;

    logic [3:0] req2;
    logic       rdy2;
    logic [3:0] gnt2;
    logic [1:0] sel2;
    logic       ov2;
    logic       bl2;

    int n_checks = 0;
    int n_errors = 0;

    mux_sel_scheduler #(.BURST(4), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .beat_last (beat_last)
    );

    mux_sel_scheduler #(.BURST(2), .CNT_W(4)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .req       (req2),
        .gnt       (gnt2),
        .sel       (sel2),
        .out_valid (ov2),
        .out_ready (rdy2),
        .beat_last (bl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sel_of(input logic [3:0] g);
        case (g)
            4'b0001: return 2'b00;
            4'b0010: return 2'b10;
            4'b0100: return 2'b01;
            4'b1000: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] rr_ref(input logic [3:0] src, input int p);
        for (int i = 0; i < 4; i++) begin
            if (src[(p + i) % 4]) return 4'(1 << ((p + i) % 4));
        end
        return 4'b0000;
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic ev, input logic eb);
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_sel"}, 32'(sel), 32'(sel_of(eg)));
        check({tag, "_valid"}, 32'(out_valid), 32'(ev));
        check({tag, "_last"}, 32'(beat_last), 32'(eb));
    endtask

    logic [3:0] m_gnt;
    logic       m_valid;
    int         m_cnt;
    int         m_ptr;
    int         waitc[4];

    initial begin
        rst = 1'b1; req = 4'b1111; out_ready = 1'b1; req2 = 4'b0000; rdy2 = 1'b1;

        // Reset values, then all requesters at release: A,B,C,D x4 each, back to back
        @(negedge clk);
        @(negedge clk);
        chk_out("rst", 4'b0000, 1'b0, 1'b0);
        check("rst_gnt2", 32'(gnt2), 32'h0);
        rst = 1'b0;
        for (int b = 0; b < 17; b++) begin
            @(negedge clk);
            chk_out("t1", 4'(1 << ((b / 4) % 4)), 1'b1, (b % 4) == 3);
        end

        // Only C requesting, consumer stalls 5 cycles
        req = 4'b0100; out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_out("t2_hold", 4'b0100, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_out("t2_go", 4'b0100, 1'b1, k == 2);
        end

        // A granted, drops request during beat 2, D takes over
        req = 4'b1001;
        do_reset();
        @(negedge clk);
        chk_out("t3_b1", 4'b0001, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("t3_b2", 4'b0001, 1'b1, 1'b0);
        req = 4'b1000;
        @(negedge clk);
        chk_out("t3_d", 4'b1000, 1'b1, 1'b0);

        // BURST=2, sole requester B is regranted without a gap
        req = 4'b0000; req2 = 4'b0010;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t4_gnt", 32'(gnt2), 32'h2);
            check("t4_sel", 32'(sel2), 32'h2);
            check("t4_valid", 32'(ov2), 32'h1);
            check("t4_last", 32'(bl2), 32'(k % 2));
        end
        req2 = 4'b0000;

        // Asynchronous reset in the middle of a burst
        req = 4'b1111;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk_out("t5_pre", 4'b0001, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("t5_async", 4'b0000, 1'b0, 1'b0);
        req = 4'b1000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_out("t5_d", 4'b1000, 1'b1, 1'b0);

        // Random traffic against a reference model, with a starvation bound
        req = 4'b0000;
        do_reset();
        m_gnt = '0; m_valid = 1'b0; m_cnt = 0; m_ptr = 0;
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n != 0) @(negedge clk);
            chk_out("rnd", m_gnt, m_valid, m_valid && (m_cnt == 4));
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            begin
                logic [3:0] src;
                logic       decide;
                decide = 1'b0;
                src    = req;
                if (!m_valid) begin
                    decide = (req != 4'b0000);
                end else if (out_ready) begin
                    if (m_cnt < 4 && req[idx_of(m_gnt)]) begin
                        m_cnt++;
                    end else begin
                        decide = 1'b1;
                        m_ptr  = (idx_of(m_gnt) + 1) % 4;
                        if ((req & ~m_gnt) != 4'b0000) src = req & ~m_gnt;
                    end
                end
                if (decide) begin
                    m_gnt   = rr_ref(src, m_ptr);
                    m_valid = (m_gnt != 4'b0000);
                    m_cnt   = m_valid ? 1 : 0;
                    for (int i = 0; i < 4; i++) begin
                        if (m_gnt[i] || !req[i]) begin
                            waitc[i] = 0;
                        end else if (m_valid) begin
                            waitc[i]++;
                            check("rnd_starve", 32'(waitc[i] <= 3), 32'h1);
                        end
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
